// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding and load-use hazard detection for decode
//
// Purpose : tracks the destination tags of the FWD_DEPTH instructions downstream of
//           decode, forwards the youngest matching stage result to each decode read
//           port, and stalls decode when a load result is not yet forwardable.
// Ports   : clk, rst_n (async active-low)
//           id_valid, id_rs, id_rd_en, id_rf_data, id_dst, id_wr_en, id_is_load, flush
//           stage_data  - result of stage k at slice k-1
//           fwd_data, fwd_hit - per-port operand and forward indication
//           stall       - hold decode, stage 1 takes a bubble
//           stall_cnt   - saturating stall-cycle counter
// Config  : define FWD_STALL_CNT_EN to build the stall counter; otherwise stall_cnt is 0.
module fwd_hazard_unit #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_RD    = 2,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        id_valid,
    input  logic [NUM_RD*ADDR_W-1:0]    id_rs,
    input  logic [NUM_RD-1:0]           id_rd_en,
    input  logic [NUM_RD*DATA_W-1:0]    id_rf_data,
    input  logic [ADDR_W-1:0]           id_dst,
    input  logic                        id_wr_en,
    input  logic                        id_is_load,
    input  logic                        flush,
    input  logic [FWD_DEPTH*DATA_W-1:0] stage_data,
    output logic [NUM_RD*DATA_W-1:0]    fwd_data,
    output logic [NUM_RD-1:0]           fwd_hit,
    output logic                        stall,
    output logic [15:0]                 stall_cnt
);

    // Index 0 holds stage 1 (youngest downstream instruction).
    logic [FWD_DEPTH-1:0] r_vld;
    logic [FWD_DEPTH-1:0] r_wen;
    logic [FWD_DEPTH-1:0] r_ld;
    logic [ADDR_W-1:0]    r_tag [FWD_DEPTH];

    logic [NUM_RD-1:0]    w_load_use;
    logic                 w_issue;

    assign stall   = id_valid & ~flush & (|w_load_use);
    assign w_issue = id_valid & ~stall & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_wen <= '0;
            r_ld  <= '0;
            for (int k = 0; k < FWD_DEPTH; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_vld[0] <= w_issue;
            r_wen[0] <= w_issue & id_wr_en;
            r_ld[0]  <= w_issue & id_is_load;
            r_tag[0] <= w_issue ? id_dst : '0;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_wen[k] <= r_wen[k-1];
                r_ld[k]  <= r_ld[k-1];
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        logic [ADDR_W-1:0] w_rs;
        logic              w_hit;
        logic              w_lu;
        logic [DATA_W-1:0] w_data;

        assign w_rs = id_rs[p*ADDR_W +: ADDR_W];

        // Scan oldest to youngest so the youngest match overwrites older ones.
        // Tag 0 is the hard-wired zero register and is never forwarded.
        always_comb begin
            w_hit  = 1'b0;
            w_lu   = 1'b0;
            w_data = id_rf_data[p*DATA_W +: DATA_W];
            for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
                if (id_rd_en[p] && r_vld[k] && r_wen[k] &&
                    (r_tag[k] == w_rs) && (w_rs != '0)) begin
                    w_hit  = 1'b1;
                    w_data = stage_data[k*DATA_W +: DATA_W];
                    // Stage k+1 holds a load whose data is not ready until stage LOAD_LAT+1.
                    w_lu   = r_ld[k] && (k < LOAD_LAT);
                end
            end
        end

        assign fwd_data[p*DATA_W +: DATA_W] = w_data;
        assign fwd_hit[p]                   = w_hit;
        assign w_load_use[p]                = w_lu;
    end

`ifdef FWD_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

    localparam int D  = 2;
    localparam int LL = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rd_en;
    logic [63:0] id_rf_data;
    logic [4:0]  id_dst;
    logic        id_wr_en;
    logic        id_is_load;
    logic        flush;
    logic [63:0] stage_data;
    logic [95:0] stage_data3;
    logic [63:0] fwd_data;
    logic [1:0]  fwd_hit;
    logic        stall;
    logic [15:0] stall_cnt;
    logic [63:0] fwd_data3;
    logic [1:0]  fwd_hit3;
    logic        stall3;
    logic [15:0] stall_cnt3;

    always #5 clk = ~clk;

    fwd_hazard_unit u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rd_en(id_rd_en), .id_rf_data(id_rf_data), .id_dst(id_dst),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
        .stage_data(stage_data), .fwd_data(fwd_data), .fwd_hit(fwd_hit),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    fwd_hazard_unit #(.FWD_DEPTH(3), .LOAD_LAT(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rd_en(id_rd_en), .id_rf_data(id_rf_data), .id_dst(id_dst),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
        .stage_data(stage_data3), .fwd_data(fwd_data3), .fwd_hit(fwd_hit3),
        .stall(stall3), .stall_cnt(stall_cnt3)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of downstream instructions, front = stage 1.
    typedef struct {
        bit       vld;
        bit       wen;
        bit       ld;
        bit [4:0] tag;
    } stage_t;

    stage_t      m_q[$];
    bit          m_stall;
    logic [15:0] m_cnt;

    task automatic model_clear();
        stage_t b;
        b = '{vld: 0, wen: 0, ld: 0, tag: 0};
        m_q.delete();
        for (int i = 0; i < D; i++) m_q.push_back(b);
        m_cnt = 16'h0;
    endtask

    task automatic settle();
        logic [63:0] e_data;
        logic [1:0]  e_hit;
        bit          lu;
        #1;
        e_data = id_rf_data;
        e_hit  = 2'b00;
        lu     = 0;
        for (int p = 0; p < 2; p++) begin
            bit [4:0] rs;
            rs = id_rs[p*5 +: 5];
            for (int k = 0; k < D; k++) begin
                if (!e_hit[p] && id_rd_en[p] && m_q[k].vld && m_q[k].wen &&
                    m_q[k].tag == rs && rs != 0) begin
                    e_hit[p] = 1'b1;
                    e_data[p*32 +: 32] = stage_data[k*32 +: 32];
                    if (m_q[k].ld && (k + 1) <= LL) lu = 1;
                end
            end
        end
        m_stall = id_valid && !flush && lu;
        check_eq("fwd_data", fwd_data, e_data);
        check_eq("fwd_hit", {62'd0, fwd_hit}, {62'd0, e_hit});
        check_eq("stall", {63'd0, stall}, {63'd0, m_stall});
        check_eq("stall_cnt", {48'd0, stall_cnt}, {48'd0, m_cnt});
    endtask

    task automatic advance();
        stage_t n;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            if (id_valid && !m_stall && !flush)
                n = '{vld: 1, wen: id_wr_en, ld: id_is_load, tag: id_dst};
            else
                n = '{vld: 0, wen: 0, ld: 0, tag: 0};
            m_q.push_front(n);
            void'(m_q.pop_back());
`ifdef FWD_STALL_CNT_EN
            if (m_stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
        end
        #1;
    endtask

    task automatic idle();
        id_valid    = 0;
        id_rs       = '0;
        id_rd_en    = '0;
        id_rf_data  = {$urandom, $urandom};
        id_dst      = '0;
        id_wr_en    = 0;
        id_is_load  = 0;
        flush       = 0;
        stage_data  = {$urandom, $urandom};
        stage_data3 = {$urandom, $urandom, $urandom};
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic issue_load4();
        idle();
        id_valid = 1; id_dst = 5'd4; id_wr_en = 1; id_is_load = 1;
        cycle();
    endtask

    task automatic consumer4(input bit wr);
        idle();
        id_valid = 1; id_rs = {5'd0, 5'd4}; id_rd_en = 2'b01;
        id_dst = 5'd4; id_wr_en = wr;
    endtask

    initial begin
        model_clear();
        m_stall = 0;
        rst_n = 0;
        idle();
        advance();
        // Reset: outputs pass register-file data through even with a reading decode
        id_valid = 1; id_rs = {5'd3, 5'd3}; id_rd_en = 2'b11;
        settle();
        check_eq("rst_stall", {63'd0, stall}, 64'd0);
        check_eq("rst_hit", {62'd0, fwd_hit}, 64'd0);
        check_eq("rst_data", fwd_data, id_rf_data);
        check_eq("rst_cnt", {48'd0, stall_cnt}, 64'd0);
        advance();
        rst_n = 1;

        // ALU back-to-back
        idle(); id_valid = 1; id_dst = 5'd3; id_wr_en = 1;
        cycle();
        idle(); id_valid = 1; id_rs = {5'd0, 5'd3}; id_rd_en = 2'b01;
        stage_data[31:0] = 32'hAAAA0001;
        settle();
        check_eq("alu_data", {32'd0, fwd_data[31:0]}, 64'hAAAA0001);
        check_eq("alu_hit", {63'd0, fwd_hit[0]}, 64'd1);
        check_eq("alu_stall", {63'd0, stall}, 64'd0);
        advance();

        // Priority: youngest of two writers to tag 7
        idle(); id_valid = 1; id_dst = 5'd7; id_wr_en = 1;
        cycle();
        idle(); id_valid = 1; id_dst = 5'd7; id_wr_en = 1;
        cycle();
        idle(); id_rs = {5'd7, 5'd0}; id_rd_en = 2'b10;
        stage_data = {32'h22, 32'h11};
        settle();
        check_eq("prio_young", {32'd0, fwd_data[63:32]}, 64'h11);
        advance();
        idle(); id_rs = {5'd7, 5'd0}; id_rd_en = 2'b10;
        stage_data = {32'h22, 32'h11};
        settle();
        check_eq("prio_old", {32'd0, fwd_data[63:32]}, 64'h22);
        advance();

        // Tag 0 never forwarded
        idle(); id_valid = 1; id_dst = 5'd0; id_wr_en = 1;
        cycle();
        idle(); id_valid = 1; id_rd_en = 2'b01;
        id_rf_data[31:0] = 32'h0; stage_data[31:0] = 32'hDEAD;
        settle();
        check_eq("tag0_data", {32'd0, fwd_data[31:0]}, 64'd0);
        check_eq("tag0_hit", {63'd0, fwd_hit[0]}, 64'd0);
        advance();

        // Load-use: 1 stall on default build, 2 stalls with LOAD_LAT=2/FWD_DEPTH=3
        for (int i = 0; i < 3; i++) begin idle(); cycle(); end
        issue_load4();
        consumer4(1);
        settle();
        check_eq("lu_stall_a", {63'd0, stall}, 64'd1);
        check_eq("lu3_stall_a", {63'd0, stall3}, 64'd1);
        advance();
        consumer4(1);
        settle();
        check_eq("lu_stall_b", {63'd0, stall}, 64'd0);
        check_eq("lu_hit_b", {63'd0, fwd_hit[0]}, 64'd1);
        check_eq("lu_data_b", {32'd0, fwd_data[31:0]}, {32'd0, stage_data[63:32]});
        check_eq("lu3_stall_b", {63'd0, stall3}, 64'd1);
        advance();
        consumer4(1);
        settle();
        check_eq("lu3_stall_c", {63'd0, stall3}, 64'd0);
        check_eq("lu3_hit_c", {63'd0, fwd_hit3[0]}, 64'd1);
        check_eq("lu3_data_c", {32'd0, fwd_data3[31:0]}, {32'd0, stage_data3[95:64]});
        advance();

        // Flush overrides load-use stall and bubbles stage 1
        for (int i = 0; i < 3; i++) begin idle(); cycle(); end
        issue_load4();
        consumer4(1);
        flush = 1;
        settle();
        check_eq("fl_stall", {63'd0, stall}, 64'd0);
        advance();
        idle(); id_rs = {5'd0, 5'd4}; id_rd_en = 2'b01;
        settle();
        check_eq("fl_hit", {63'd0, fwd_hit[0]}, 64'd1);
        check_eq("fl_data", {32'd0, fwd_data[31:0]}, {32'd0, stage_data[63:32]});
        advance();

        // Counter: fresh reset, then three single-cycle load-use stalls
        rst_n = 0; idle();
        advance();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            issue_load4();
            consumer4(0); cycle();
            consumer4(0); cycle();
        end
        idle();
        settle();
`ifdef FWD_STALL_CNT_EN
        check_eq("cnt_three", {48'd0, stall_cnt}, 64'd3);
`else
        check_eq("cnt_tied", {48'd0, stall_cnt}, 64'd0);
`endif
        advance();

        // Asynchronous reset in the middle of a stall
        issue_load4();
        consumer4(0);
        settle();
        rst_n = 0;
        #1;
        check_eq("rst_mid_stall", {63'd0, stall}, 64'd0);
        check_eq("rst_mid_cnt", {48'd0, stall_cnt}, 64'd0);
        check_eq("rst_mid_hit", {62'd0, fwd_hit}, 64'd0);
        check_eq("rst_mid_data", fwd_data, id_rf_data);
        advance();
        rst_n = 1;
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            id_valid    = ($urandom % 4) != 0;
            id_rs       = {5'($urandom % 8), 5'($urandom % 8)};
            id_rd_en    = 2'($urandom);
            id_rf_data  = {$urandom, $urandom};
            id_dst      = 5'($urandom % 8);
            id_wr_en    = 1'($urandom);
            id_is_load  = ($urandom % 3) == 0;
            flush       = ($urandom % 8) == 0;
            stage_data  = {$urandom, $urandom};
            stage_data3 = {$urandom, $urandom, $urandom};
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- DATA_W, 32, operand width.
- ADDR_W, 5, register-tag width.
- NUM_RD, 2, number of decode read ports.
- FWD_DEPTH, 2, number of downstream stages tracked (legal 1..4).
- LOAD_LAT, 1, load data becomes forwardable only in stages k > LOAD_LAT (legal 0..FWD_DEPTH-1).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  decode instruction valid.
- id_rs  in  NUM_RD*ADDR_W  source tags, port p at [p*ADDR_W +: ADDR_W].
- id_rd_en  in  NUM_RD  port p actually reads its register.
- id_rf_data  in  NUM_RD*DATA_W  register-file read data per port.
- id_dst  in  ADDR_W  decode destination tag.
- id_wr_en  in  1  decode instruction writes id_dst.
- id_is_load  in  1  decode instruction is a load.
- flush  in  1  squash the decode instruction.
- stage_data  in  FWD_DEPTH*DATA_W  result of stage k (k=1..FWD_DEPTH) at slice k-1.
- fwd_data  out  NUM_RD*DATA_W  forwarded operand per port.
- fwd_hit  out  NUM_RD  port p took forwarded data.
- stall  out  1  hold decode, bubble inserted.
- stall_cnt  out  16  saturating stall-cycle count (see REQ-019).

Function
REQ-003 SHALL hold an internal tag pipeline per stage k: vld[k], tag[k], wen[k], ld[k].
REQ-004 SHALL on every clock shift stage k-1 into stage k for k>=2; the downstream pipeline never stalls.
REQ-005 SHALL load stage 1 from decode (vld=1, tag=id_dst, wen=id_wr_en, ld=id_is_load) when id_valid=1, stall=0 and flush=0; otherwise stage 1 SHALL load a bubble (vld=0, wen=0, ld=0).
REQ-006 SHALL define a match on port p at stage k as: id_rd_en[p]=1, vld[k]=1, wen[k]=1, tag[k]==rs_p, and rs_p!=0.
REQ-007 SHALL select per port the youngest matching stage (lowest k); older matches SHALL be ignored.
REQ-008 SHALL drive fwd_data[p]=stage_data[k] and fwd_hit[p]=1 for the selected k; with no match, fwd_data[p]=id_rf_data[p] and fwd_hit[p]=0.
REQ-009 SHALL treat register tag 0 as never forwarded, even if some stage has wen=1 with tag 0.
REQ-010 SHALL assert stall combinationally when id_valid=1, flush=0, and any port's selected stage k has ld[k]=1 and k<=LOAD_LAT.
REQ-011 SHALL keep fwd_data and fwd_hit defined by REQ-008 during stall; the consumer ignores them.
REQ-012 SHALL, with LOAD_LAT=0, never assert stall.
REQ-013 SHALL produce multi-cycle stalls naturally: the bubble advances until the load reaches stage LOAD_LAT+1, then stall deasserts in that same cycle.
REQ-014 SHALL give flush priority over stall: flush=1 forces stall=0 and a stage-1 bubble.
REQ-015 SHALL evaluate all ports independently; a stall caused by any one port stalls the instruction.

Reset
REQ-016 SHALL on rst_n=0 asynchronously clear all vld, wen, ld and tag to 0 and stall_cnt to 0.
REQ-017 SHALL, while in reset, drive stall=0, fwd_hit=0 and fwd_data=id_rf_data.
REQ-018 SHALL resume normal operation on the first rising clk after rst_n deasserts; an in-flight stall is discarded by reset.

Configuration
REQ-019 SHALL include stall_cnt only when macro FWD_STALL_CNT_EN is defined: counter increments on each clk with stall=1 and saturates at 16'hFFFF; when undefined, stall_cnt SHALL be tied to 16'h0000 with no counter flops.

Verification
REQ-020 Bench SHALL cover these scenarios (defaults unless stated):
- ALU back-to-back: stage1 {tag=3, wen=1, ld=0}, stage_data[0]=32'hAAAA0001, decode rs0=3 -> fwd_data[0]=32'hAAAA0001, fwd_hit[0]=1, stall=0.
- Priority: stage1 and stage2 both write tag 7 (32'h11 / 32'h22), rs1=7 -> fwd_data[1]=32'h11; stage1 then bubble -> 32'h22.
- Load-use: load to tag 4 in stage1, rs0=4 -> stall=1 for exactly 1 cycle, stage1 bubble; next cycle fwd from stage2, stall=0; with LOAD_LAT=2, FWD_DEPTH=3 -> 2 stall cycles.
- Tag 0: stage1 writes tag 0 with 32'hDEAD, rs0=0, id_rf_data=0 -> fwd_data[0]=0, fwd_hit[0]=0.
- Flush during load-use: condition of the load-use case plus flush=1 -> stall=0, stage1 bubble next cycle.
- Reset/counter: 3 stall cycles with FWD_STALL_CNT_EN defined -> stall_cnt=3; async rst_n low mid-stall -> stall=0 and stall_cnt=0 immediately; macro undefined -> stall_cnt=0 throughout.
